// File: rtl/mem_bus_pkg.sv
// Shared definitions for the CPU-side memory bus: sequencer states and the
// memory-mapped I/O addresses decoded by the memory control unit.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RECOVER
  } mem_seq_state_t;

  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

endpackage

// File: rtl/mem_access_sequencer.sv
// CPU-side bus initiator: holds one read/write on the memory bus for a fixed
// window, captures read data, pulses a response and enforces a recovery gap.
//
//   state   | meaning
//   IDLE    | ready; a valid request is registered onto the bus
//   ACCESS  | MIO_EN high, bus fields frozen, counting down the access window
//   RECOVER | MIO_EN low, Address held, counting down the inter-access gap
module mem_access_sequencer
  import mem_bus_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req_Valid,
  input  logic        Req_Write,
  input  logic [15:0] Req_Addr,
  input  logic [15:0] Req_Data,
  output logic        Req_Ready,
  output logic        Rsp_Valid,
  output logic [15:0] Rsp_Data,
  output logic        MIO_EN,
  output logic        R_W,
  output logic [15:0] Address,
  output logic [15:0] Data_FromCPU,
  input  logic [15:0] Data_ToCPU
);

  localparam int CNT_MAX = (WAIT_CYCLES > GAP_CYCLES) ? WAIT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  mem_seq_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mio_en_q, mio_en_d;
  logic           r_w_q, r_w_d;
  logic [15:0]    addr_q, addr_d;
  logic [15:0]    wdata_q, wdata_d;
  logic [15:0]    rsp_data_q, rsp_data_d;
  logic           rsp_valid_q, rsp_valid_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mio_en_q    <= 1'b0;
      r_w_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mio_en_q    <= mio_en_d;
      r_w_q       <= r_w_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (Req_Valid) begin
          state_d = ACCESS;
          cnt_d   = WAIT_LOAD;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RECOVER;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RECOVER: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output registers hold by default; only the response pulse self-clears.
  always_comb begin
    mio_en_d    = mio_en_q;
    r_w_d       = r_w_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (Req_Valid) begin
          mio_en_d = 1'b1;
          r_w_d    = Req_Write;
          addr_d   = Req_Addr;
          wdata_d  = Req_Data;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!r_w_q) begin
            rsp_data_d = Data_ToCPU;
          end
          rsp_valid_d = 1'b1;
          mio_en_d    = 1'b0;
          r_w_d       = 1'b0;
        end
      end
      default: begin
        mio_en_d = 1'b0;
        r_w_d    = 1'b0;
      end
    endcase
  end

  assign Req_Ready    = (state_q == IDLE);
  assign Rsp_Valid    = rsp_valid_q;
  assign Rsp_Data     = rsp_data_q;
  assign MIO_EN       = mio_en_q;
  assign R_W          = r_w_q;
  assign Address      = addr_q;
  assign Data_FromCPU = wdata_q;

endmodule
